mod_counter: RTL and testbench
==============================

Name: mod_counter

Overview:
Parametrised modulo counter and the next generation of the team's fixed 3-bit done-counter. WIDTH-bit count register with run-time terminal value, up/down direction, parallel load, and a wrap or one-shot mode. Emits a registered one-cycle done pulse on reaching terminal. Used as the cycle and timeout counter for multi-cycle datapath sequencing in the CPU.

Parameters:
WIDTH, 4, count register and limit width in bits (legal range 1..16).

Ports:
clk  input  1  rising-edge clock.
reset_in  input  1  one clock; reset is synchronous and active-high.
enable  input  1  advance count by one step on this edge (RUN state only).
start  input  1  arm or restart: load start value, enter RUN.
oneshot  input  1  0 = wrap mode, 1 = one-shot mode; sampled only on the start edge.
dir  input  1  0 = up, 1 = down.
limit  input  WIDTH  terminal value for up mode; start value for down mode.
load  input  1  parallel load request.
load_val  input  WIDTH  value written on load.
count  output  WIDTH  current count (registered).
done  output  1  registered one-cycle terminal pulse.
busy  output  1  high while state is RUN.

Behaviour:
- Reset (reset_in high at the edge): count=0, done=0, state=IDLE, busy=0, latched mode=wrap. Reset overrides every other input.
- Edge priority: reset_in > load > start > enable.
- Terminal value: limit when up, 0 when down. Start value: 0 when up, limit when down. dir is sampled every edge; a change takes effect on the next enabled step.
- FSM states:
  - IDLE: count holds. start -> RUN, count=start value, mode latched from oneshot.
  - RUN: each enable edge steps the count.
    - Up: count+1. If count >= limit, the count becomes 0 (wrap).
    - Down: count-1. If count == 0, the count becomes limit (wrap).
    - When the stepped value equals the terminal value, done=1 on that same edge.
    - In one-shot mode that edge also moves to DONE, and count holds the terminal value.
    - In wrap mode the state stays RUN, and the next enabled step wraps.
  - DONE: count holds, busy=0. start -> RUN (re-arm). RUN never returns to IDLE except via reset.
- done: set only by a stepping edge that lands on the terminal value, and cleared on the following edge. It never stays high two consecutive cycles unless consecutive steps each land on terminal.
- Latency: count and done update on the enable edge itself and are visible the next cycle. There is no combinational path from inputs to outputs.
- limit=0:
  - Up mode: every enabled step yields count=0 with done=1, so done stays high continuously while enable is held.
  - Down mode: likewise, count stays 0 with done each step.
- Out-of-range count (count > limit, after a load or a limit decrease):
  - Up: the next step goes to 0, with no done unless limit==0.
  - Down: the count steps down normally toward 0.
- load: count=load_val, done=0, state unchanged. This holds in every state, including IDLE and DONE. Loading the terminal value does not pulse done.
- start while RUN: restart at start value, done=0, mode re-latched.
- enable and start both high: start wins, and no step occurs that edge.
- Arithmetic: unsigned, modulo 2^WIDTH. No carry or borrow output.

Decomposition:
- Package mod_counter_pkg holds:
  - state encoding: ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10; 2'b11 is illegal and recovers to IDLE.
  - constants DIR_UP=0, DIR_DOWN=1, MODE_WRAP=0, MODE_ONESHOT=1.
- One sub-module, count_reg: a WIDTH-bit register with synchronous active-high clear, enable, and data input. It is built from the team's D flip-flop cell. Next-value mux, terminal compare and FSM stay in mod_counter.

Test Plan:
- WIDTH=4, limit=3, up, wrap, start then enable held -> count 0,1,2,3,0,1,2,3. done high exactly in cycles where count=3. busy=1 throughout.
- limit=5, down, one-shot, start then enable held -> count 5,4,3,2,1,0, then holds 0. done pulses once, busy drops with done. A further start re-arms to 5.
- Up, limit=9, load with load_val=12 mid-run -> count=12 next cycle, no done. Next enable gives 0, still no done.
- Reset mid-run: reset_in=1 together with load and start at count=7 -> next cycle count=0, done=0, busy=0, state IDLE.
- limit=0, up, wrap, enable held 4 cycles -> count stays 0, done=1 on all 4 cycles.
- WIDTH=4, limit=15, up, wrap -> count 14,15,0 with done at 15. Dir flipped to down at count=2 -> next step gives 1.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared state encoding and direction/mode constants for mod_counter.
package mod_counter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;
  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;
endpackage

// File: rtl/mod_counter_count_reg.sv
// WIDTH-bit register with synchronous clear and load enable.
module count_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (clr)     q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with run-time limit, load, wrap/one-shot modes and done pulse.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             enable,
  input  logic             start,
  input  logic             oneshot,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             busy
);
  state_e           state;
  logic             mode;
  logic             step, hit, cnt_en;
  logic [WIDTH-1:0] start_val, term_val, step_val, next_val;

  assign start_val = (dir == DIR_DOWN) ? limit : '0;
  assign term_val  = (dir == DIR_DOWN) ? '0 : limit;
  assign step      = (state == ST_RUN) && enable && !load && !start;

  // Out-of-range counts (above limit) fall back to 0 on the next up step.
  always_comb begin
    step_val = '0;
    if (dir == DIR_UP) step_val = (count >= limit) ? '0 : count + WIDTH'(1);
    else               step_val = (count == '0) ? limit : count - WIDTH'(1);
  end

  assign hit    = step && (step_val == term_val);
  assign cnt_en = load || start || step;

  always_comb begin
    next_val = step_val;
    if (load)       next_val = load_val;
    else if (start) next_val = start_val;
  end

  count_reg #(.WIDTH(WIDTH)) u_count_reg (
    .clk (clk),
    .clr (reset_in),
    .en  (cnt_en),
    .d   (next_val),
    .q   (count)
  );

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state <= ST_IDLE;
      mode  <= MODE_WRAP;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= hit;
      if (load) begin
        state <= state;
      end else if (start) begin
        state <= ST_RUN;
        busy  <= 1'b1;
        mode  <= oneshot;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: busy <= 1'b0;
          ST_RUN: begin
            if (hit && mode == MODE_ONESHOT) begin
              state <= ST_DONE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mod_counter.sv
// Randomized and directed check of mod_counter against a behavioural model.
module tb_mod_counter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_in, enable, start, oneshot, dir, load;
  logic [W-1:0] limit, load_val, count;
  logic         done, busy;

  int total = 0;
  int bad   = 0;

  // model: phase 0=idle 1=run 2=finished
  int m_cnt, m_ph;
  bit m_done, m_os;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(W)) dut (
    .clk(clk), .reset_in(reset_in), .enable(enable), .start(start),
    .oneshot(oneshot), .dir(dir), .limit(limit), .load(load),
    .load_val(load_val), .count(count), .done(done), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int lim, nxt, term;
    lim = int'(limit);
    if (reset_in) begin
      m_cnt = 0; m_done = 0; m_ph = 0; m_os = 0;
    end else if (load) begin
      m_cnt = int'(load_val); m_done = 0;
    end else if (start) begin
      m_cnt = dir ? lim : 0; m_ph = 1; m_os = oneshot; m_done = 0;
    end else if (m_ph == 1 && enable) begin
      if (!dir) begin
        nxt  = (m_cnt >= lim) ? 0 : m_cnt + 1;
        term = lim;
      end else begin
        nxt  = (m_cnt == 0) ? lim : m_cnt - 1;
        term = 0;
      end
      m_cnt  = nxt;
      m_done = (nxt == term);
      if (m_done && m_os) m_ph = 2;
    end else begin
      m_done = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("count", 32'(count), 32'(m_cnt));
    chk("done",  32'(done),  32'(m_done));
    chk("busy",  32'(busy),  32'(m_ph == 1));
  endtask

  task automatic idle_in();
    reset_in = 0; enable = 0; start = 0; load = 0;
  endtask

  initial begin
    reset_in = 1; enable = 0; start = 0; oneshot = 0; dir = 0; load = 0;
    limit = '0; load_val = '0;
    m_cnt = 0; m_ph = 0; m_done = 0; m_os = 0;
    cyc();
    chk("rst_count", 32'(count), 0);
    chk("rst_busy",  32'(busy),  0);

    // up wrap, limit 3
    idle_in(); limit = 3; dir = 0; oneshot = 0; start = 1;
    cyc();
    start = 0; enable = 1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("wrap_seq", 32'(count), 32'((i + 1) % 4));
      chk("wrap_done", 32'(done), 32'(((i + 1) % 4) == 3));
    end

    // down one-shot, limit 5
    idle_in(); limit = 5; dir = 1; oneshot = 1; start = 1;
    cyc();
    chk("os_start", 32'(count), 5);
    start = 0; enable = 1;
    for (int i = 0; i < 7; i++) cyc();
    chk("os_hold", 32'(count), 0);
    chk("os_busy", 32'(busy), 0);
    enable = 0; start = 1;
    cyc();
    chk("os_rearm", 32'(count), 5);

    // out-of-range load in up mode
    idle_in(); limit = 9; dir = 0; oneshot = 0; start = 1;
    cyc();
    start = 0; enable = 1;
    cyc(); cyc();
    load = 1; load_val = 12;
    cyc();
    chk("load12", 32'(count), 12);
    chk("load12_done", 32'(done), 0);
    load = 0;
    cyc();
    chk("oor_step", 32'(count), 0);
    chk("oor_done", 32'(done), 0);

    // reset beats load and start
    load = 1; load_val = 7;
    cyc();
    reset_in = 1; start = 1; load = 1;
    cyc();
    chk("rst_mid", 32'(count), 0);
    chk("rst_mid_busy", 32'(busy), 0);

    // limit 0 up wrap
    idle_in(); limit = 0; dir = 0; oneshot = 0; start = 1;
    cyc();
    start = 0; enable = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("lim0_done", 32'(done), 1);
    end

    // full range wrap and direction flip
    idle_in(); limit = 15; dir = 0; oneshot = 0; start = 1;
    cyc();
    start = 0; enable = 1;
    for (int i = 0; i < 14; i++) cyc();
    chk("c14", 32'(count), 14);
    cyc();
    chk("c15_done", 32'(done), 1);
    cyc();
    chk("c0", 32'(count), 0);
    cyc(); cyc();
    dir = 1;
    cyc();
    chk("flip", 32'(count), 1);

    // random
    for (int i = 0; i < 3000; i++) begin
      reset_in = ($urandom_range(63) == 0);
      load     = ($urandom_range(15) == 0);
      start    = ($urandom_range(9) == 0);
      enable   = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0)  dir = ~dir;
      if ($urandom_range(15) == 0) limit = W'($urandom_range(15));
      oneshot  = $urandom_range(1);
      load_val = W'($urandom_range(15));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
